// File: rtl/jtvigil_snd_pkg.sv
// Shared constants for the Vigilante sound-CPU command interface.
//  - Z80 IO port map of the sound side (low address byte)
//  - IM0 RST opcodes placed on the bus during interrupt acknowledge
//  - sample-fetch FSM state type
package jtvigil_snd_pkg;

    // IO ports seen by the sound Z80
    localparam logic [7:0] PORT_LATCH   = 8'h80;  // read: command byte from main CPU
    localparam logic [7:0] PORT_ADDR_LO = 8'h80;  // write: sample address bits 7:0
    localparam logic [7:0] PORT_ADDR_HI = 8'h81;  // write: sample address bits 15:8
    localparam logic [7:0] PORT_DAC     = 8'h82;  // write: DAC sample
    localparam logic [7:0] PORT_IRQ_ACK = 8'h83;  // write: clear the latch interrupt
    localparam logic [7:0] PORT_SMP     = 8'h84;  // read: fetch one sample byte

    // RST opcodes: each pending source pulls one bit of 8'hff low
    localparam logic [7:0] VEC_NONE  = 8'hff;  // RST 38h
    localparam logic [7:0] VEC_LATCH = 8'hdf;  // RST 18h
    localparam logic [7:0] VEC_YM    = 8'hef;  // RST 28h
    localparam logic [7:0] VEC_BOTH  = 8'hcf;  // RST 08h

    localparam logic [7:0] DAC_RESET = 8'h80;  // DAC mid-scale (silence)

    typedef enum logic [1:0] {
        SMP_IDLE,
        SMP_FETCH,
        SMP_HOLD
    } smp_state_t;

endpackage

// File: rtl/jtvigil_snd_smp.sv
// Sample-ROM fetch engine: address counter plus the IDLE/FETCH/HOLD FSM that
// stretches a Z80 read of the sample port with WAIT until the ROM answers.
// Ports:
//  clk, rst_n     clock, async active-low reset
//  fetch_req      sample-port read decoded this clk
//  bus_release    rd_n or iorq_n high: the CPU has ended its read
//  addr_lo_wr     one-clk strobe: load address bits 7:0 from wr_data
//  addr_hi_wr     one-clk strobe: load address bits 15:8 from wr_data
//  wr_data        sound Z80 data out
//  smp_ok         ROM data valid
//  smp_data       ROM data
//  smp_addr       ROM address (counter)
//  smp_cs         ROM request
//  wait_n         Z80 WAIT, low during a fetch
//  sdata          last fetched byte
//  hold           high in HOLD: sdata is being driven to the CPU
module jtvigil_snd_smp
    import jtvigil_snd_pkg::*;
#(
    parameter int SMP_AW = 16   // must be at least 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic              bus_release,
    input  logic              addr_lo_wr,
    input  logic              addr_hi_wr,
    input  logic [7:0]        wr_data,
    input  logic              smp_ok,
    input  logic [7:0]        smp_data,
    output logic [SMP_AW-1:0] smp_addr,
    output logic              smp_cs,
    output logic              wait_n,
    output logic [7:0]        sdata,
    output logic              hold
);

    smp_state_t        state, state_nx;
    logic [SMP_AW-1:0] addr_nx;
    logic              cs_nx;
    logic              wait_nx;
    logic [7:0]        sdata_nx;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SMP_IDLE;
            smp_addr <= '0;
            smp_cs   <= 1'b0;
            wait_n   <= 1'b1;
            sdata    <= 8'h00;
        end else begin
            state    <= state_nx;
            smp_addr <= addr_nx;
            smp_cs   <= cs_nx;
            wait_n   <= wait_nx;
            sdata    <= sdata_nx;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        addr_nx  = smp_addr;
        cs_nx    = smp_cs;
        wait_nx  = wait_n;
        sdata_nx = sdata;
        case (state)
            SMP_IDLE: begin
                // Address loads rebuild the counter from its low 16 bits so
                // anything above bit 15 is cleared.
                if (addr_lo_wr)
                    addr_nx = SMP_AW'({smp_addr[15:8], wr_data});
                else if (addr_hi_wr)
                    addr_nx = SMP_AW'({wr_data, smp_addr[7:0]});
                if (fetch_req) begin
                    // WAIT drops at the detecting edge, well before T2 ends.
                    state_nx = SMP_FETCH;
                    wait_nx  = 1'b0;
                    cs_nx    = 1'b1;
                end
            end
            SMP_FETCH: begin
                if (smp_ok) begin
                    state_nx = SMP_HOLD;
                    sdata_nx = smp_data;
                    wait_nx  = 1'b1;
                    cs_nx    = 1'b0;
                    addr_nx  = smp_addr + SMP_AW'(1);
                end
            end
            SMP_HOLD: begin
                if (bus_release)
                    state_nx = SMP_IDLE;
            end
            default: state_nx = SMP_IDLE;
        endcase
    end

    assign hold = (state == SMP_HOLD);

endmodule

// File: rtl/jtvigil_snd_if.sv
// Sound-CPU side of the main->sound command path for Vigilante.
// Captures the main CPU command byte, raises the sound Z80 IM0 interrupt
// (merged with the YM2151 IRQ into a single RST vector), decodes the sound
// IO ports and hosts the sample fetch engine and DAC register.
// Ports:
//  clk, rst_n              clock, async active-low reset
//  latch_wr, main_dout     main CPU command strobe (level) and data
//  A, iorq_n, m1_n, rd_n,
//  wr_n, cpu_dout          sound Z80 bus
//  ym_irq_n                YM2151 interrupt, active low
//  io_din                  data to the sound Z80 (IO reads, int-ack vector)
//  int_n, wait_n           sound Z80 INT and WAIT
//  smp_addr, smp_cs,
//  smp_data, smp_ok        sample ROM port
//  dac                     unsigned DAC sample
module jtvigil_snd_if
    import jtvigil_snd_pkg::*;
#(
    parameter int SMP_AW = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              latch_wr,
    input  logic [7:0]        main_dout,
    input  logic [7:0]        A,
    input  logic              iorq_n,
    input  logic              m1_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [7:0]        cpu_dout,
    input  logic              ym_irq_n,
    output logic [7:0]        io_din,
    output logic              int_n,
    output logic              wait_n,
    output logic [SMP_AW-1:0] smp_addr,
    output logic              smp_cs,
    input  logic [7:0]        smp_data,
    input  logic              smp_ok,
    output logic [7:0]        dac
);

    logic       latch_wr_l;     // delayed strobe for edge detection
    logic       io_wr_l;        // IO write seen last clk
    logic [7:0] latch;
    logic       latch_irq;
    logic [7:0] sdata;
    logic       hold;

    logic latch_edge, io_cyc, int_ack, io_rd, io_wr, wr_stb;

    assign latch_edge = latch_wr & ~latch_wr_l;
    assign io_cyc     = ~iorq_n &  m1_n;
    assign int_ack    = ~iorq_n & ~m1_n;
    assign io_rd      = io_cyc & ~rd_n;
    assign io_wr      = io_cyc & ~wr_n;
    // Writes act only on the first clk of the IO write cycle.
    assign wr_stb     = io_wr & ~io_wr_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_wr_l <= 1'b0;
            io_wr_l    <= 1'b0;
            latch      <= 8'h00;
            latch_irq  <= 1'b0;
            dac        <= DAC_RESET;
        end else begin
            latch_wr_l <= latch_wr;
            io_wr_l    <= io_wr;
            if (latch_edge)
                latch <= main_dout;
            // A new command wins over a same-clk acknowledge write.
            if (latch_edge)
                latch_irq <= 1'b1;
            else if (wr_stb && A == PORT_IRQ_ACK)
                latch_irq <= 1'b0;
            if (wr_stb && A == PORT_DAC)
                dac <= cpu_dout;
        end
    end

    assign int_n = ~(latch_irq | ~ym_irq_n);

    always_comb begin
        io_din = VEC_NONE;
        if (int_ack) begin
            case ({latch_irq, ~ym_irq_n})
                2'b11:   io_din = VEC_BOTH;
                2'b10:   io_din = VEC_LATCH;
                2'b01:   io_din = VEC_YM;
                default: io_din = VEC_NONE;
            endcase
        end else if (hold && !rd_n) begin
            io_din = sdata;
        end else if (io_rd && A == PORT_LATCH) begin
            io_din = latch;
        end
    end

    jtvigil_snd_smp #(.SMP_AW(SMP_AW)) u_smp (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (io_rd && A == PORT_SMP),
        .bus_release (rd_n | iorq_n),
        .addr_lo_wr  (wr_stb && A == PORT_ADDR_LO),
        .addr_hi_wr  (wr_stb && A == PORT_ADDR_HI),
        .wr_data     (cpu_dout),
        .smp_ok      (smp_ok),
        .smp_data    (smp_data),
        .smp_addr    (smp_addr),
        .smp_cs      (smp_cs),
        .wait_n      (wait_n),
        .sdata       (sdata),
        .hold        (hold)
    );

endmodule

// File: tb/tb_jtvigil_snd_if.sv
// Self-checking bench for jtvigil_snd_if: directed scenarios followed by a
// random mix of bus operations, all compared against a behavioural model of
// the register file, interrupt sources and sample ROM.
module tb_jtvigil_snd_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        latch_wr = 1'b0;
    logic [7:0]  main_dout = 8'h00;
    logic [7:0]  A = 8'h00;
    logic        iorq_n = 1'b1;
    logic        m1_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [7:0]  cpu_dout = 8'h00;
    logic        ym_irq_n = 1'b1;
    logic [7:0]  io_din;
    logic        int_n;
    logic        wait_n;
    logic [15:0] smp_addr;
    logic        smp_cs;
    logic [7:0]  smp_data;
    logic        smp_ok;
    logic [7:0]  dac;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model
    logic [7:0]  m_latch;
    logic        m_irq;
    logic [15:0] m_addr;
    logic [7:0]  m_dac;

    jtvigil_snd_if #(.SMP_AW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .latch_wr  (latch_wr),
        .main_dout (main_dout),
        .A         (A),
        .iorq_n    (iorq_n),
        .m1_n      (m1_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .cpu_dout  (cpu_dout),
        .ym_irq_n  (ym_irq_n),
        .io_din    (io_din),
        .int_n     (int_n),
        .wait_n    (wait_n),
        .smp_addr  (smp_addr),
        .smp_cs    (smp_cs),
        .smp_data  (smp_data),
        .smp_ok    (smp_ok),
        .dac       (dac)
    );

    always #5 clk = ~clk;

    // Sample ROM: fixed scrambled contents, answers ok_dly clks after smp_cs rises.
    int ok_dly = 1;
    int cs_cnt = 0;

    function automatic logic [7:0] rom(input logic [15:0] a);
        return a[7:0] ^ {a[14:8], a[15]} ^ 8'h3c;
    endfunction

    always @(posedge clk) cs_cnt <= smp_cs ? cs_cnt + 1 : 0;
    assign smp_ok   = smp_cs && (cs_cnt + 1 >= ok_dly);
    assign smp_data = rom(smp_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_int_n();
        return !(m_irq || !ym_irq_n);
    endfunction

    function automatic logic [7:0] exp_vector();
        case ({m_irq, !ym_irq_n})
            2'b11:   return 8'hcf;
            2'b10:   return 8'hdf;
            2'b01:   return 8'hef;
            default: return 8'hff;
        endcase
    endfunction

    task automatic model_reset();
        m_latch = 8'h00;
        m_irq   = 1'b0;
        m_addr  = 16'h0000;
        m_dac   = 8'h80;
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_int_n"},  int_n,    exp_int_n());
        check({tag, "_dac"},    dac,      m_dac);
        check({tag, "_addr"},   smp_addr, m_addr);
        check({tag, "_wait_n"}, wait_n,   1'b1);
    endtask

    task automatic strobe(input logic [7:0] d, input int hold_clks);
        @(negedge clk);
        main_dout = d;
        latch_wr  = 1'b1;
        @(negedge clk);
        m_latch = d;
        m_irq   = 1'b1;
        check("strobe_int_n", int_n, 1'b0);
        // Changing data while the strobe stays high must not recapture.
        for (int i = 1; i < hold_clks; i++) begin
            main_dout = 8'($urandom);
            @(negedge clk);
        end
        latch_wr  = 1'b0;
        main_dout = 8'($urandom);
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int hold_clks);
        @(negedge clk);
        A = a; cpu_dout = d; iorq_n = 1'b0; m1_n = 1'b1; wr_n = 1'b0;
        repeat (hold_clks) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        case (a)
            8'h80: m_addr[7:0]  = d;
            8'h81: m_addr[15:8] = d;
            8'h82: m_dac        = d;
            8'h83: m_irq        = 1'b0;
            default: ;
        endcase
    endtask

    task automatic io_read(input logic [7:0] a);
        @(negedge clk);
        A = a; iorq_n = 1'b0; m1_n = 1'b1; rd_n = 1'b0;
        #1;
        check("io_read", io_din, (a == 8'h80) ? m_latch : 8'hff);
        @(negedge clk);
        iorq_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic int_ack();
        @(negedge clk);
        iorq_n = 1'b0; m1_n = 1'b0;
        #1;
        check("int_ack_vec", io_din, exp_vector());
        @(negedge clk);
        iorq_n = 1'b1; m1_n = 1'b1;
    endtask

    task automatic fetch(input int dly);
        int  waits;
        bit  done;
        waits  = 0;
        done   = 1'b0;
        ok_dly = dly;
        @(negedge clk);
        A = 8'h84; iorq_n = 1'b0; m1_n = 1'b1; rd_n = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!wait_n) begin
                waits++;
                if (waits == 1) check("fetch_cs_on", smp_cs, 1'b1);
            end else begin
                done = 1'b1;
            end
        end
        check("fetch_done", done, 1'b1);
        check("fetch_wait_clks", waits, dly);
        check("fetch_data", io_din, rom(m_addr));
        check("fetch_cs_off", smp_cs, 1'b0);
        iorq_n = 1'b1; rd_n = 1'b1;
        m_addr = m_addr + 16'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        model_reset();

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_dac", dac, 8'h80);
        check("rst_addr", smp_addr, 16'h0000);
        check("rst_cs", smp_cs, 1'b0);
        check("rst_wait_n", wait_n, 1'b1);
        check("rst_int_n", int_n, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_state("post_rst");

        // 1: long strobe captures once
        strobe(8'h5a, 10);
        io_read(8'h80);
        check_state("t1");

        // 2: merged vector, ack does not clear, then latch-only clear
        ym_irq_n = 1'b0;
        int_ack();
        int_ack();
        io_write(8'h83, 8'h00, 2);
        int_ack();
        ym_irq_n = 1'b1;
        check_state("t2");

        // 3: clear write and latch edge in the same clk; write held 2 clk
        @(negedge clk);
        A = 8'h83; cpu_dout = 8'h00; iorq_n = 1'b0; m1_n = 1'b1; wr_n = 1'b0;
        latch_wr = 1'b1; main_dout = 8'ha7;
        repeat (2) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; latch_wr = 1'b0;
        m_latch = 8'ha7;
        m_irq   = 1'b1;
        check_state("t3");
        int_ack();
        io_read(8'h80);

        // 4: address wrap on fetch
        io_write(8'h80, 8'hff, 1);
        io_write(8'h81, 8'hff, 3);
        check_state("t4_pre");
        fetch(5);
        check_state("t4");

        // 5: DAC write and unmapped read
        io_write(8'h82, 8'h12, 2);
        check_state("t5");
        io_read(8'h90);

        // 6: reset in the middle of a fetch
        strobe(8'h33, 1);
        ym_irq_n = 1'b1;
        ok_dly   = 20;
        @(negedge clk);
        A = 8'h84; iorq_n = 1'b0; m1_n = 1'b1; rd_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_fetching", wait_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_cs", smp_cs, 1'b0);
        check("t6_wait_n", wait_n, 1'b1);
        check("t6_dac", dac, 8'h80);
        check("t6_int_n", int_n, ym_irq_n);
        iorq_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        ok_dly = 1;
        check_state("t6");

        // Random mix
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 6))
                0: strobe(8'($urandom), $urandom_range(1, 4));
                1: io_write(8'($urandom_range(8'h80, 8'h83)), 8'($urandom), $urandom_range(1, 3));
                2: begin
                    a = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'($urandom);
                    if (a == 8'h84) a = 8'h85;
                    io_read(a);
                end
                3: fetch($urandom_range(1, 6));
                4: int_ack();
                5: begin
                    @(negedge clk);
                    ym_irq_n = 1'($urandom);
                end
                default: begin
                    a = 8'($urandom);
                    if (a >= 8'h80 && a <= 8'h83) a = 8'h84;
                    io_write(a, 8'($urandom), $urandom_range(1, 3));
                end
            endcase
            check_state("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
